arc4_encrypt: RTL
=================

Name: arc4_encrypt

Overview:
- Encrypts a length-prefixed plaintext buffer into a length-prefixed ciphertext buffer using RC4 with a 24-bit key. It is the transmit-side counterpart of the cracking/decrypt path.
- Produces ciphertext memories that the decrypt and crack datapaths consume.
- Owns the S-box RAM exclusively while busy. It runs init, KSA and PRGA in one FSM and XORs each keystream byte with plaintext as it goes.

Parameters:
- KEY_BYTES, 3, key length in bytes; key byte i%3 selects key[23-8*(i%3) -: 8] (MSB byte first).
- MEM_DEPTH, 256, depth of the S, PT and CT memories; fixed 8-bit addresses.

Ports:
- clk  in  1  single system clock.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  start request; sampled only while rdy=1.
- rdy  out  1  idle/accepting.
- key  in  24  RC4 key, captured on accept.
- s_addr  out  8  S-box RAM address.
- s_rddata  in  8  S-box read data.
- s_wrdata  out  8  S-box write data.
- s_wren  out  1  S-box write enable.
- pt_addr  out  8  plaintext RAM address (read-only).
- pt_rddata  in  8  plaintext read data.
- ct_addr  out  8  ciphertext RAM address.
- ct_wrdata  out  8  ciphertext write data.
- ct_wren  out  1  ciphertext write enable.

Behaviour:
- Clock and reset:
  - One clock; reset is synchronous and active-low (clk, rst_n).
  - Reset values: rdy=1, all wren=0, all addr=0, all wrdata=0, FSM=IDLE, i=j=k=0.
- Memory timing: all RAMs have 1-cycle read latency. Data for an address driven in cycle N is valid on *_rddata in cycle N+1. Writes commit at the clock edge where wren=1.
- Handshake:
  - en && rdy at a clock edge captures key; rdy=0 from the next cycle.
  - rdy returns to 1 one cycle after the final CT write.
  - en while rdy=0 is ignored.
  - en held high at completion starts a new job immediately with the key present at that edge.
- FSM states: IDLE -> INIT -> KSA_RDI -> KSA_RDJ -> KSA_WRI -> KSA_WRJ -> (repeat 256) -> LEN_RD -> LEN_WR -> PRGA_RDI -> PRGA_RDJ -> PRGA_WRI -> PRGA_WRJ -> PRGA_RDPAD -> PRGA_RDPT -> PRGA_WRCT -> (repeat len) -> IDLE. Wait cycles are inserted wherever read latency requires.
- INIT: write s[i]=i for i=0..255, 256 cycles.
- KSA: j starts at 0. For i=0..255:
  - j = (j + s[i] + keybyte[i%3]) mod 256, using 8-bit wrapping adds.
  - Swap s[i] and s[j] via two writes; the i==j case writes the same value twice (harmless).
- Length:
  - Read pt[0] = len, then write ct[0] = len.
  - len=0: no PRGA iterations; go to IDLE after the ct[0] write.
- PRGA: i=j=0. For k=1..len:
  - i = i+1; j = j + s[i]; swap s[i], s[j].
  - pad = s[(s[i]+s[j]) mod 256], using post-swap values.
  - ct[k] = pad ^ pt[k].
  - len=255 is legal; k must not wrap (9-bit compare or terminal test on k==len).
- Write-enable rules:
  - At most one write per memory per cycle; s_wren and ct_wren are never high in IDLE.
  - pt is never written.
  - S-box contents after completion are the post-PRGA state; do not clear them.
- Reset mid-operation: return to IDLE with the reset values above within the same edge. Partial S/CT contents are left as-is; a following job must fully reinitialise.
- Latency bound: total busy cycles ≤ 256 + 256*6 + 4 + len*9. The bench checks this upper bound, not an exact count.

Decomposition:
- Shared package arc4_pkg holds:
  - the state enum for this FSM;
  - S_DEPTH=256 and KEY_BYTES=3 constants;
  - a keybyte(key, idx) function returning the MSB-first byte for idx mod 3. The crack/decrypt path also uses this function.
- Single module; no sub-module is required. The init/KSA phase may later be factored into an arc4_ksa sub-module shared with the decrypt path, but the FSM here is flat.

Test Plan:
- Standard vector: key=0x4B6579 ("Key"), pt = 9,"Plaintext" -> ct = 09 BB F3 16 E8 D9 40 AF 0A D3; rdy rises; ct[10..255] untouched.
- Zero length: pt[0]=0, any key -> only ct[0]=0 written (one ct_wren pulse); rdy=1 shortly after KSA completes.
- Round trip: encrypt 16-byte message with key=0x000018, copy ct into pt, re-run same key -> second ct equals the original plaintext byte-for-byte.
- Handshake: pulse en twice mid-job with different keys -> ignored, output matches first key. Hold en high at completion -> second job starts the next cycle with the new key.
- Mid-op reset: assert rst_n=0 for 1 cycle during KSA, then restart with key=0x4B6579 -> outputs reset that edge; final ct matches the standard vector.
- Max length: len=255, key=0x00033C -> 256 ct writes; ct[255] matches the bench model; no write to address 0 after ct[0].

Source files
------------

// File: rtl/arc4_pkg.sv
// Shared RC4 definitions: FSM state encoding, sizing constants and key byte selection.
package arc4_pkg;

    localparam int unsigned S_DEPTH   = 256;
    localparam int unsigned KEY_BYTES = 3;

    typedef enum logic [3:0] {
        StIdle,
        StInit,
        StKsaRdi,
        StKsaRdj,
        StKsaWri,
        StKsaWrj,
        StLenRd,
        StLenWr,
        StPrgaRdi,
        StPrgaRdj,
        StPrgaWri,
        StPrgaWrj,
        StPrgaRdpad,
        StPrgaRdpt,
        StPrgaWrct
    } arc4_state_e;

    // Key bytes are taken MSB first: idx 0 -> key[23:16].
    function automatic logic [7:0] keybyte(input logic [23:0] key, input int unsigned idx);
        case (idx % KEY_BYTES)
            0:       return key[23:16];
            1:       return key[15:8];
            default: return key[7:0];
        endcase
    endfunction

endpackage

// File: rtl/arc4_encrypt.sv
// RC4 encryptor: initialises and keys the S-box, then XORs the keystream over a
// length-prefixed plaintext buffer into a length-prefixed ciphertext buffer.
module arc4_encrypt #(
    parameter int unsigned KEY_BYTES = 3,
    parameter int unsigned MEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        rdy,
    input  logic [23:0] key,
    output logic [7:0]  s_addr,
    input  logic [7:0]  s_rddata,
    output logic [7:0]  s_wrdata,
    output logic        s_wren,
    output logic [7:0]  pt_addr,
    input  logic [7:0]  pt_rddata,
    output logic [7:0]  ct_addr,
    output logic [7:0]  ct_wrdata,
    output logic        ct_wren
);
    import arc4_pkg::*;

    localparam logic [7:0] LAST_IDX = 8'(MEM_DEPTH - 1);
    localparam logic [1:0] LAST_KB  = 2'(KEY_BYTES - 1);

    arc4_state_e state_q, state_d;
    logic [23:0] key_q, key_d;
    logic [7:0]  i_q, i_d, j_q, j_d;
    logic [8:0]  k_q, k_d;
    logic [1:0]  kidx_q, kidx_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  si_q, si_d, sj_q, sj_d;
    logic [7:0]  pad_q, pad_d;
    logic [7:0]  j_new;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            key_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            kidx_q  <= '0;
            len_q   <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            pad_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            kidx_q  <= kidx_d;
            len_q   <= len_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            pad_q   <= pad_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        kidx_d    = kidx_q;
        len_d     = len_q;
        si_d      = si_q;
        sj_d      = sj_q;
        pad_d     = pad_q;
        j_new     = '0;
        rdy       = 1'b0;
        s_addr    = '0;
        s_wrdata  = '0;
        s_wren    = 1'b0;
        pt_addr   = '0;
        ct_addr   = '0;
        ct_wrdata = '0;
        ct_wren   = 1'b0;

        case (state_q)
            StIdle: begin
                rdy = 1'b1;
                if (en) begin
                    key_d   = key;
                    i_d     = '0;
                    j_d     = '0;
                    kidx_d  = '0;
                    state_d = StInit;
                end
            end
            StInit: begin
                s_addr   = i_q;
                s_wrdata = i_q;
                s_wren   = 1'b1;
                i_d      = i_q + 8'd1;    // wraps back to 0 for the KSA pass
                if (i_q == LAST_IDX) state_d = StKsaRdi;
            end
            StKsaRdi: begin
                s_addr  = i_q;
                state_d = StKsaRdj;
            end
            StKsaRdj: begin
                j_new   = j_q + s_rddata + keybyte(key_q, 32'(kidx_q));
                si_d    = s_rddata;
                j_d     = j_new;
                s_addr  = j_new;
                state_d = StKsaWri;
            end
            StKsaWri: begin
                sj_d     = s_rddata;
                s_addr   = i_q;
                s_wrdata = s_rddata;
                s_wren   = 1'b1;
                state_d  = StKsaWrj;
            end
            StKsaWrj: begin
                s_addr   = j_q;
                s_wrdata = si_q;
                s_wren   = 1'b1;
                i_d      = i_q + 8'd1;
                kidx_d   = (kidx_q == LAST_KB) ? 2'd0 : kidx_q + 2'd1;
                if (i_q == LAST_IDX) begin
                    j_d     = '0;
                    state_d = StLenRd;
                end else begin
                    state_d = StKsaRdi;
                end
            end
            StLenRd: begin
                pt_addr = '0;
                state_d = StLenWr;
            end
            StLenWr: begin
                len_d     = pt_rddata;
                ct_addr   = '0;
                ct_wrdata = pt_rddata;
                ct_wren   = 1'b1;
                k_d       = 9'd1;
                i_d       = '0;
                j_d       = '0;
                state_d   = (pt_rddata == 8'd0) ? StIdle : StPrgaRdi;
            end
            StPrgaRdi: begin
                i_d     = i_q + 8'd1;
                s_addr  = i_q + 8'd1;
                state_d = StPrgaRdj;
            end
            StPrgaRdj: begin
                j_new   = j_q + s_rddata;
                si_d    = s_rddata;
                j_d     = j_new;
                s_addr  = j_new;
                state_d = StPrgaWri;
            end
            StPrgaWri: begin
                sj_d     = s_rddata;
                s_addr   = i_q;
                s_wrdata = s_rddata;
                s_wren   = 1'b1;
                state_d  = StPrgaWrj;
            end
            StPrgaWrj: begin
                s_addr   = j_q;
                s_wrdata = si_q;
                s_wren   = 1'b1;
                state_d  = StPrgaRdpad;
            end
            StPrgaRdpad: begin
                // Post-swap s[i]+s[j] equals the pre-swap pair summed.
                s_addr  = si_q + sj_q;
                state_d = StPrgaRdpt;
            end
            StPrgaRdpt: begin
                pad_d   = s_rddata;
                pt_addr = k_q[7:0];
                state_d = StPrgaWrct;
            end
            StPrgaWrct: begin
                ct_addr   = k_q[7:0];
                ct_wrdata = pad_q ^ pt_rddata;
                ct_wren   = 1'b1;
                if (k_q == {1'b0, len_q}) begin
                    state_d = StIdle;
                end else begin
                    k_d     = k_q + 9'd1;
                    state_d = StPrgaRdi;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule
